// File: rtl/tristate_seq.sv
// Half-duplex sequencer for the tristate port cell: MSB-first write on io[0], bus turnaround, optional MSB-first read.
// Latency: WIDTH+TURN+1 busy cycles after start (plus WIDTH when reading); done pulses in the last busy cycle.
// Backpressure: none; start is only honoured in IDLE, all outputs are registered state decodes.
module tristate_seq #(
  parameter int WIDTH = 8,
  parameter int TURN  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       tri_o,
  output logic             tri_en,
  output logic             tri_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             err
);

  localparam int MAXC = (WIDTH > TURN) ? WIDTH : TURN;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] LOAD_W = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LOAD_T = CW'(TURN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_TURN,
    S_READ,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] wsh;
  logic [WIDTH-1:0] rsh;
  logic             rd_q;

  // Only io[0] carries data; the io[1] readback is not needed by this sequencer.
  logic unused_io1;
  assign unused_io1 = tri_o[1];

  // Sequencer FSM; tri_i is preloaded with the next MSB so the driven bit is always a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wsh    <= '0;
      rsh    <= '0;
      rd_q   <= 1'b0;
      tri_en <= 1'b0;
      tri_i  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_WRITE;
            wsh    <= wdata;
            rd_q   <= rd_en;
            err    <= 1'b0;
            cnt    <= LOAD_W;
            tri_en <= 1'b1;
            tri_i  <= wdata[WIDTH-1];
            busy   <= 1'b1;
          end
        end
        S_WRITE: begin
          // Loopback must match what we are driving, otherwise someone else is on the line.
          if (tri_o[0] != tri_i) begin
            err <= 1'b1;
          end
          wsh <= {wsh[WIDTH-2:0], 1'b0};
          if (cnt == '0) begin
            state  <= S_TURN;
            cnt    <= LOAD_T;
            tri_en <= 1'b0;
            // i must go low too, since the cell drives io[1] whenever i is high.
            tri_i  <= 1'b0;
          end else begin
            cnt   <= cnt - 1'b1;
            tri_i <= wsh[WIDTH-2];
          end
        end
        S_TURN: begin
          if (cnt == '0) begin
            if (rd_q) begin
              state <= S_READ;
              cnt   <= LOAD_W;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_READ: begin
          rsh <= {rsh[WIDTH-2:0], tri_o[0]};
          if (cnt == '0) begin
            rdata <= {rsh[WIDTH-2:0], tri_o[0]};
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          tri_en <= 1'b0;
          tri_i  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_seq.sv
// Bench for tristate_seq with an inline model of the tristate cell plus a pull-down/driver on io.
// Per-cycle expectations come from the transaction timeline; completions are checked through a scoreboard queue.
// The bench driver can overdrive io[0] to create contention or supply read data.
module tb_tristate_seq;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic       start;
  logic       rd_en;
  logic [7:0] wdata;
  logic [1:0] tri_o;
  logic       tri_en;
  logic       tri_i;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       err;

  // Bench-side driver on io[0]; it wins over the cell so contention is visible on readback.
  logic drv_en;
  logic drv_val;
  logic io0;

  assign io0   = drv_en ? drv_val : (tri_en ? tri_i : 1'b0);
  assign tri_o = {tri_i, io0};

  tristate_seq #(.WIDTH(8), .TURN(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rd_en (rd_en),
    .wdata (wdata),
    .tri_o (tri_o),
    .tri_en(tri_en),
    .tri_i (tri_i),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .err   (err)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         done_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rdata_model;
  int         n_chk;
  int         n_fail;

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One transaction; contend = write cycle overdriven low (0 = none), guard = extra start pulses,
  // rst_at = cycle in which reset is asserted (0 = none).
  task automatic run_txn(input logic [7:0] wd, input logic rd, input logic [7:0] rsp,
                         input int contend, input bit guard, input int rst_at);
    int   last;
    int   dones;
    exp_t e;
    exp_t g;
    logic exp_en;
    logic exp_ti;
    logic exp_err;
    last  = 8 + 2 + (rd ? 8 : 0) + 1;
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    wdata = wd;
    rd_en = rd;
    e.rdata    = rd ? rsp : rdata_model;
    e.err      = (contend > 0);
    e.done_cyc = last;
    sb.push_back(e);
    for (int k = 1; k <= last + 2; k++) begin
      @(negedge clk);
      start   = 1'b0;
      wdata   = 8'($urandom);
      rd_en   = 1'($urandom);
      drv_en  = 1'b0;
      drv_val = 1'b0;
      if (rst_at == k) begin
        rst_n = 1'b0;
        #1;
        chk("rst_tri_en", 32'(tri_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_no_done", dones, 0);
        void'(sb.pop_front());
        rdata_model = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == contend) begin
        drv_en  = 1'b1;
        drv_val = 1'b0;
      end
      if (rd && k >= 11 && k <= 18) begin
        drv_en  = 1'b1;
        drv_val = rsp[18-k];
      end
      if (guard && (k == 5 || k == last)) begin
        start = 1'b1;
        wdata = 8'h00;
        rd_en = 1'b1;
      end
      #1;
      exp_en  = (k >= 1 && k <= 8);
      exp_ti  = exp_en ? wd[8-k] : 1'b0;
      exp_err = (contend > 0) && (k > contend);
      chk("tri_en", 32'(tri_en), 32'(exp_en));
      chk("tri_i", 32'(tri_i), 32'(exp_ti));
      chk("busy", 32'(busy), 32'(k <= last));
      chk("done", 32'(done), 32'(k == last));
      chk("err", 32'(err), 32'(exp_err));
      if (k != contend) chk("overlap", 32'(tri_en & drv_en), 32'd0);
      if (done) begin
        dones++;
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          g = sb.pop_front();
          chk("sb_rdata", 32'(rdata), 32'(g.rdata));
          chk("sb_err", 32'(err), 32'(g.err));
          chk("sb_done_cyc", k, g.done_cyc);
          rdata_model = g.rdata;
        end
      end
    end
    drv_en = 1'b0;
    chk("done_count", dones, 1);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rdata_model = 8'h00;
    clk_run     = 1'b0;
    rst_n       = 1'b1;
    start       = 1'b0;
    rd_en       = 1'b0;
    wdata       = 8'h00;
    drv_en      = 1'b0;
    drv_val     = 1'b0;

    // Reset with the clock stopped: outputs must clear asynchronously.
    #3;
    rst_n = 1'b0;
    #1;
    chk("init_tri_en", 32'(tri_en), 32'd0);
    chk("init_tri_i", 32'(tri_i), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_err", 32'(err), 32'd0);
    chk("init_rdata", 32'(rdata), 32'd0);
    #10;
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write+read: response C3 sent MSB-first.
    run_txn(8'h3C, 1'b1, 8'hC3, 0, 1'b0, 0);
    // Write-only: rdata must keep C3.
    run_txn(8'hA5, 1'b0, 8'h00, 0, 1'b0, 0);
    // Contention in write cycle 3 of FF.
    run_txn(8'hFF, 1'b0, 8'h00, 3, 1'b0, 0);
    // Next start clears err; extra start pulses must be ignored.
    run_txn(8'hC6, 1'b0, 8'h00, 0, 1'b1, 0);
    // Reset in read cycle 14.
    run_txn(8'h3C, 1'b1, 8'h81, 0, 1'b0, 14);
    repeat (2) @(negedge clk);
    // Recovery transaction after reset.
    run_txn(8'h5A, 1'b1, 8'h96, 0, 1'b0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
